// File: rtl/data_mem_bytelane_pkg.sv
// Shared constants for the byte-lane data memory: access sizes and
// the sequencer state encoding.
package data_mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_mem_bytelane_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] din;
    logic        rsp_valid;
    logic [31:0] dout;
    logic        err_misalign;
    logic        err_range;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, addr, din,
        input  req_ready, rsp_valid, dout, err_misalign, err_range
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, addr, din,
        output req_ready, rsp_valid, dout, err_misalign, err_range
    );

endinterface

// File: rtl/data_mem_bytelane_lane_align.sv
// Big-endian byte-lane steering: store lane mask and shifted data,
// load extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] din,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Decode lanes per size; mask bit 3 is byte [31:24] (offset 0).
    always_comb begin
        wmask    = '0;
        wdata    = '0;
        ldata    = '0;
        misalign = 1'b0;
        half_v   = '0;
        byte_v   = '0;
        case (size)
            SIZE_WORD: begin
                misalign = (off != 2'b00);
                wmask    = 4'b1111;
                wdata    = din;
                ldata    = rdata;
            end
            SIZE_HALF: begin
                misalign = off[0];
                wmask    = off[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{din[15:0]}};
                half_v   = off[1] ? rdata[15:0] : rdata[31:16];
                ldata    = {{16{half_v[15] & ~is_unsigned}}, half_v};
            end
            SIZE_BYTE: begin
                wmask = 4'b1000 >> off;
                wdata = {4{din[7:0]}};
                case (off)
                    2'd0:    byte_v = rdata[31:24];
                    2'd1:    byte_v = rdata[23:16];
                    2'd2:    byte_v = rdata[15:8];
                    default: byte_v = rdata[7:0];
                endcase
                ldata = {{24{byte_v[7] & ~is_unsigned}}, byte_v};
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressed data memory with init sequencer and a registered
// request stage followed by a registered response stage.
module data_mem_bytelane
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic               clka,
    input  logic               rst,
    data_mem_bytelane_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             p_valid;
    logic             p_we;
    logic [1:0]       p_size;
    logic             p_uns;
    logic [1:0]       p_off;
    logic [IDX_W-1:0] p_idx;
    logic [31:0]      p_din;
    logic             p_rng;

    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic [31:0]      ldata;
    logic             mis;
    logic             p_err;
    logic             p_store;

    assign bus.req_ready = (state == ST_READY);
    assign accept        = (state == ST_READY) && bus.req_valid;
    assign p_err         = mis | p_rng;
    assign p_store       = p_valid & p_we & ~p_err;

    mem_lane_align u_align (
        .size        (p_size),
        .off         (p_off),
        .din         (p_din),
        .is_unsigned (p_uns),
        .rdata       (mem[p_idx]),
        .wmask       (wmask),
        .wdata       (wdata),
        .ldata       (ldata),
        .misalign    (mis)
    );

    // Init sequencer: clear one word per cycle, then serve requests.
    always_ff @(posedge clka) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            // DEPTH_WORDS is a power of two, so all-ones is the last word.
            if (&init_idx) begin
                state <= ST_READY;
            end
        end
    end

    // Storage: init clears whole words, stores write enabled lanes only.
    always_ff @(posedge clka) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[init_idx] <= '0;
            end else if (p_store) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wmask[i]) begin
                        mem[p_idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Request stage: capture an accepted request for the access cycle.
    always_ff @(posedge clka) begin
        if (rst) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_we   <= bus.req_we;
                p_size <= bus.req_size;
                p_uns  <= bus.req_unsigned;
                p_off  <= bus.addr[1:0];
                p_idx  <= bus.addr[IDX_W+1:2];
                p_din  <= bus.din;
                p_rng  <= |bus.addr[31:IDX_W+2];
            end
        end
    end

    // Response stage: one-cycle pulse with load data or error flags.
    always_ff @(posedge clka) begin
        if (rst) begin
            bus.rsp_valid    <= 1'b0;
            bus.dout         <= '0;
            bus.err_misalign <= 1'b0;
            bus.err_range    <= 1'b0;
        end else begin
            bus.rsp_valid    <= p_valid;
            bus.err_misalign <= p_valid & mis;
            bus.err_range    <= p_valid & p_rng;
            bus.dout         <= (p_valid && !p_we && !p_err) ? ldata : '0;
        end
    end

endmodule
